// File: rtl/led_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_driver
// Purpose  : Per-channel LED output stage. Each channel selects one of four
//            modes (follow, PWM dim, gated blink, pulse stretch) through a
//            small configuration write port. Pin drive is registered and
//            presented at board polarity.
// Ports    : clk        - sole clock, rising edge
//            reset      - synchronous, active-high
//            led_value  - logical lit request per channel
//            cfg_we     - configuration write strobe (one cycle per write)
//            cfg_sel    - target channel for the write
//            cfg_mode   - 00 follow, 01 PWM, 10 blink, 11 stretch
//            cfg_duty   - PWM duty for the channel
//            led_pins   - pin drive, bit i = lit_i XOR ACTIVE_LOW
// Revision : 1.0 - initial release
// ============================================================================
module led_driver #(
  parameter int N_LEDS         = 10,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int PWM_BITS       = 4,
  parameter int BLINK_DIV      = 25_000_000,
  parameter int STRETCH_CYCLES = 2_500_000
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [N_LEDS-1:0]                                 led_value,
  input  logic                                              cfg_we,
  input  logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0]    cfg_sel,
  input  logic [1:0]                                        cfg_mode,
  input  logic [PWM_BITS-1:0]                               cfg_duty,
  output logic [N_LEDS-1:0]                                 led_pins
);

  localparam int SEL_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int PRESC_W = $clog2(BLINK_DIV);
  localparam int STR_W   = $clog2(STRETCH_CYCLES + 1);

  // One extra bit so the range check also works when N_LEDS is a power of two.
  localparam logic [SEL_W:0]     N_LEDS_EXT   = (SEL_W + 1)'(N_LEDS);
  localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(BLINK_DIV - 1);
  localparam logic [STR_W-1:0]   STRETCH_LOAD = STR_W'(STRETCH_CYCLES);

  localparam logic [1:0] MODE_FOLLOW  = 2'b00;
  localparam logic [1:0] MODE_PWM     = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_STRETCH = 2'b11;

  // Per-channel state
  logic [1:0]          mode_q    [N_LEDS];
  logic [1:0]          mode_d    [N_LEDS];
  logic [PWM_BITS-1:0] duty_q    [N_LEDS];
  logic [PWM_BITS-1:0] duty_d    [N_LEDS];
  logic [STR_W-1:0]    stretch_q [N_LEDS];
  logic [STR_W-1:0]    stretch_d [N_LEDS];
  logic [N_LEDS-1:0]   prev_q, prev_d;

  // Shared timebases
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                blink_phase_q, blink_phase_d;

  logic [N_LEDS-1:0]   led_pins_q, led_pins_d;
  logic [N_LEDS-1:0]   lit;
  logic [N_LEDS-1:0]   rise;
  logic                cfg_hit;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    if (presc_q == PRESC_LAST) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      presc_d       = presc_q + PRESC_W'(1);
      blink_phase_d = blink_phase_q;
    end

    // Out-of-range selects are dropped entirely, never aliased onto a channel.
    cfg_hit = cfg_we && ({1'b0, cfg_sel} < N_LEDS_EXT);
    rise    = led_value & ~prev_q;
    prev_d  = led_value;
    lit     = '0;

    for (int i = 0; i < N_LEDS; i++) begin
      mode_d[i] = mode_q[i];
      duty_d[i] = duty_q[i];

      // Output uses the mode held before this edge, so a new mode shows one
      // cycle after the write.
      case (mode_q[i])
        MODE_FOLLOW:  lit[i] = led_value[i];
        MODE_PWM:     lit[i] = led_value[i] && (pwm_cnt_q < duty_q[i]);
        MODE_BLINK:   lit[i] = led_value[i] && blink_phase_q;
        default:      lit[i] = led_value[i] || (stretch_q[i] != '0);
      endcase

      // A write to the channel always clears its stretch; outside stretch mode
      // the counter sits at zero; a rising edge reloads (no accumulation).
      if (cfg_hit && (cfg_sel == SEL_W'(i))) begin
        mode_d[i]    = cfg_mode;
        duty_d[i]    = cfg_duty;
        stretch_d[i] = '0;
      end else if (mode_q[i] != MODE_STRETCH) begin
        stretch_d[i] = '0;
      end else if (rise[i]) begin
        stretch_d[i] = STRETCH_LOAD;
      end else if (stretch_q[i] != '0) begin
        stretch_d[i] = stretch_q[i] - STR_W'(1);
      end else begin
        stretch_d[i] = stretch_q[i];
      end
    end

    led_pins_d = lit ^ {N_LEDS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_LEDS; i++) begin
        mode_q[i]    <= MODE_FOLLOW;
        duty_q[i]    <= '0;
        stretch_q[i] <= '0;
      end
      prev_q        <= '0;
      pwm_cnt_q     <= '0;
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      led_pins_q    <= {N_LEDS{ACTIVE_LOW}};
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        mode_q[i]    <= mode_d[i];
        duty_q[i]    <= duty_d[i];
        stretch_q[i] <= stretch_d[i];
      end
      prev_q        <= prev_d;
      pwm_cnt_q     <= pwm_cnt_d;
      presc_q       <= presc_d;
      blink_phase_q <= blink_phase_d;
      led_pins_q    <= led_pins_d;
    end
  end

  assign led_pins = led_pins_q;

endmodule
`default_nettype wire

// File: tb/tb_led_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_driver
// Purpose  : Self-checking bench for led_driver. An active-low and an
//            active-high build share one stimulus; a time-based reference
//            model predicts the lit state of every channel each cycle, and
//            directed literal checks pin the key behaviours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_driver;

  localparam int N  = 10;
  localparam int PB = 4;
  localparam int BD = 4;
  localparam int S  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  led_value;
  logic          cfg_we;
  logic [3:0]    cfg_sel;
  logic [1:0]    cfg_mode;
  logic [PB-1:0] cfg_duty;
  logic [N-1:0]  led_pins;
  logic [N-1:0]  led_pins_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_driver #(
    .N_LEDS(N), .ACTIVE_LOW(1'b1), .PWM_BITS(PB), .BLINK_DIV(BD), .STRETCH_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .led_value(led_value), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led_pins(led_pins)
  );

  led_driver #(
    .N_LEDS(N), .ACTIVE_LOW(1'b0), .PWM_BITS(PB), .BLINK_DIV(BD), .STRETCH_CYCLES(S)
  ) dut_hi (
    .clk(clk), .reset(reset), .led_value(led_value), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led_pins(led_pins_hi)
  );

  // ---------------- reference model (time since reset / since trigger) -----
  int          n;             // non-reset edges since last reset
  logic [1:0]  m_mode [N];
  int          m_duty [N];
  bit          m_act  [N];    // a stretch trigger is on record
  int          m_load [N];    // edge index of that trigger
  logic [N-1:0] m_prev;
  logic [N-1:0] exp_lit;
  bit          model_ok = 1'b0;

  function automatic logic model_lit(int i);
    case (m_mode[i])
      2'b00:   return led_value[i];
      2'b01:   return led_value[i] && ((n % (1 << PB)) < m_duty[i]);
      2'b10:   return led_value[i] && (((n / BD) % 2) == 1);
      default: return led_value[i] || (m_act[i] && ((n - m_load[i]) <= S));
    endcase
  endfunction

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = model_lit(i);
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n        <= 0;
      m_prev   <= '0;
      exp_lit  <= '0;
      model_ok <= 1'b1;
      for (int i = 0; i < N; i++) begin
        m_mode[i] <= 2'b00;
        m_duty[i] <= 0;
        m_act[i]  <= 1'b0;
      end
    end else begin
      exp_lit <= model_vec();
      for (int i = 0; i < N; i++) begin
        if (cfg_we && (int'(cfg_sel) < N) && (int'(cfg_sel) == i)) begin
          m_mode[i] <= cfg_mode;
          m_duty[i] <= int'(cfg_duty);
          m_act[i]  <= 1'b0;
        end else if (m_mode[i] != 2'b11) begin
          m_act[i] <= 1'b0;
        end else if (led_value[i] && !m_prev[i]) begin
          m_act[i]  <= 1'b1;
          m_load[i] <= n;
        end
      end
      m_prev <= led_value;
      n      <= n + 1;
    end
  end

  // Every-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks = checks + 1;
      if (led_pins !== ~exp_lit) begin
        errors = errors + 1;
        $display("FAIL model_lo t=%0t: got %h, expected %h", $time, led_pins, ~exp_lit);
      end
      checks = checks + 1;
      if (led_pins_hi !== exp_lit) begin
        errors = errors + 1;
        $display("FAIL model_hi t=%0t: got %h, expected %h", $time, led_pins_hi, exp_lit);
      end
    end
  end

  // ---------------- directed helpers --------------------------------------
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] sel, input logic [1:0] mode, input logic [PB-1:0] duty);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_mode = mode;
    cfg_duty = duty;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Counts cycles in which pin ch of the active-low build is lit.
  task automatic count_lit(input int ch, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (led_pins[ch] == 1'b0) cnt++;
    end
  endtask

  // Drives channel 7 with 1-cycle pulses at the listed iterations and counts lit cycles.
  task automatic pulse_run(input int p0, input int p1, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      led_value[7] = (i == p0) || (i == p1);
      @(negedge clk);
      if (led_pins[7] == 1'b0) cnt++;
    end
    led_value[7] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [5:0] samp;

    reset = 1'b1; led_value = '1; cfg_we = 1'b0;
    cfg_sel = '0; cfg_mode = '0; cfg_duty = '0;
    repeat (3) @(negedge clk);
    check_val("reset_pins_lo", 32'(led_pins), 32'h3FF);
    check_val("reset_pins_hi", 32'(led_pins_hi), 32'h000);

    reset = 1'b0;
    @(negedge clk);
    check_val("follow_after_release", 32'(led_pins), 32'h000);

    // Out-of-range select must not touch any channel.
    cfg_write(4'd12, 2'b01, 4'd0);
    repeat (2) @(negedge clk);
    check_val("cfg_sel_out_of_range", 32'(led_pins), 32'h000);

    // PWM on channel 3.
    cfg_write(4'd3, 2'b01, 4'd4);
    @(negedge clk);
    count_lit(3, 16, cnt);
    check_val("pwm_duty4_count", 32'(cnt), 32'd4);
    cfg_write(4'd3, 2'b01, 4'd0);
    @(negedge clk);
    count_lit(3, 16, cnt);
    check_val("pwm_duty0_count", 32'(cnt), 32'd0);

    // Blink on channel 0.
    cfg_write(4'd0, 2'b10, 4'd0);
    @(negedge clk);
    count_lit(0, 16, cnt);
    check_val("blink_count", 32'(cnt), 32'd8);
    led_value[0] = 1'b0;
    @(negedge clk);
    count_lit(0, 16, cnt);
    check_val("blink_gated_off", 32'(cnt), 32'd0);
    led_value[0] = 1'b1;

    // Stretch on channel 7.
    led_value[7] = 1'b0;
    cfg_write(4'd7, 2'b11, 4'd0);
    repeat (2) @(negedge clk);
    pulse_run(0, -1, 12, cnt);
    check_val("stretch_single", 32'(cnt), 32'd6);
    pulse_run(0, 3, 14, cnt);
    check_val("stretch_retrigger", 32'(cnt), 32'd9);

    // Cfg write to channel 7 in the middle of a stretch.
    for (int i = 0; i < 6; i++) begin
      led_value[7] = (i == 0);
      cfg_we   = (i == 2);
      cfg_sel  = 4'd7;
      cfg_mode = 2'b11;
      cfg_duty = 4'd0;
      @(negedge clk);
      samp[i] = ~led_pins[7];
    end
    cfg_we = 1'b0;
    check_val("midstretch_write_edge", 32'(samp[2]), 32'd1);
    check_val("midstretch_cleared", 32'(samp[5:3]), 32'd0);

    // Reset mid-blink / mid-stretch: everything dark.
    led_value = '1;
    led_value[7] = 1'b0;
    @(negedge clk);
    led_value[7] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_midrun_lo", 32'(led_pins), 32'h3FF);
    check_val("reset_midrun_hi", 32'(led_pins_hi), 32'h000);

    // Reset beats a simultaneous cfg write.
    cfg_we = 1'b1; cfg_sel = 4'd1; cfg_mode = 2'b01; cfg_duty = 4'd0;
    @(negedge clk);
    reset = 1'b0; cfg_we = 1'b0; led_value = '1;
    repeat (2) @(negedge clk);
    check_val("reset_beats_cfg", 32'(led_pins), 32'h000);
    check_val("reset_beats_cfg_hi", 32'(led_pins_hi), 32'h3FF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
